// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//  - redirect_kind_e : how decode asks to steer the next fetch
//  - fetch_state_e   : fetch FSM state encoding
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    RK_BRANCH = 2'b00,  // pc-relative, only when the branch is taken
    RK_JUMP   = 2'b01,  // absolute target from imm
    RK_JR     = 2'b10,  // absolute target from a register
    RK_JAL    = 2'b11   // absolute target from imm, link address consumed by decode
  } redirect_kind_e;

  typedef enum logic {
    ST_FETCH = 1'b0,    // ROM address presented, waiting out the read latency
    ST_VALID = 1'b1     // instruction held toward decode until accepted
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction ROM and decode.
// master : fetch unit side (drives ROM address and the decode-facing outputs)
// slave  : ROM + decode side (drives ROM data, ready, redirect and flush)
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32'd8,
  parameter int unsigned DATA_W = 32'd32
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] link_addr;
  logic              redirect_valid;
  logic [1:0]        redirect_kind;
  logic              branch_taken;
  logic [15:0]       imm;
  logic [DATA_W-1:0] jr_target;
  logic              flush_valid;
  logic [ADDR_W-1:0] flush_pc;
  logic [31:0]       fetch_count;

  modport master (
    output rom_addr, instr_valid, instr, instr_pc, link_addr, fetch_count,
    input  rom_q, instr_ready, redirect_valid, redirect_kind, branch_taken,
           imm, jr_target, flush_valid, flush_pc
  );

  modport slave (
    input  rom_addr, instr_valid, instr, instr_pc, link_addr, fetch_count,
    output rom_q, instr_ready, redirect_valid, redirect_kind, branch_taken,
           imm, jr_target, flush_valid, flush_pc
  );

endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Next-PC resolution for the instruction currently being accepted by decode.
// Ports:
//  instr_pc_i       address of the accepted instruction
//  redirect_valid_i decode is redirecting the stream
//  kind_i           redirect kind (branch / jump / jr / jal)
//  taken_i          branch condition, meaningful for branches only
//  imm_i            16-bit immediate of the accepted instruction
//  jr_target_i      register value used by jr
//  next_pc_o        address of the next fetch (all arithmetic mod 2^ADDR_W)
module fetch_unit_next_pc_calc
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32'd8,
  parameter int unsigned DATA_W = 32'd32
) (
  input  logic [ADDR_W-1:0] instr_pc_i,
  input  logic              redirect_valid_i,
  input  logic [1:0]        kind_i,
  input  logic              taken_i,
  input  logic [15:0]       imm_i,
  input  logic [DATA_W-1:0] jr_target_i,
  output logic [ADDR_W-1:0] next_pc_o
);

  logic [ADDR_W-1:0] seq_pc_s;
  logic              unused_s;

  assign seq_pc_s = instr_pc_i + ADDR_W'(1);
  // Bits above ADDR_W never influence the target.
  assign unused_s = ^{imm_i, jr_target_i};

  // Target selection. Because ADDR_W <= 16, sign-extending imm and then
  // truncating to ADDR_W is simply its low ADDR_W bits.
  always_comb begin
    next_pc_o = seq_pc_s;
    if (redirect_valid_i) begin
      case (redirect_kind_e'(kind_i))
        RK_BRANCH: begin
          if (taken_i) begin
            next_pc_o = seq_pc_s + imm_i[ADDR_W-1:0];
          end else begin
            next_pc_o = seq_pc_s;
          end
        end
        RK_JUMP, RK_JAL: next_pc_o = imm_i[ADDR_W-1:0];
        RK_JR:           next_pc_o = jr_target_i[ADDR_W-1:0];
        default:         next_pc_o = seq_pc_s;
      endcase
    end else begin
      next_pc_o = seq_pc_s;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the synchronous ROM,
// waits out ROM_LAT cycles and holds each instruction toward decode on a
// valid/ready handshake. Only one fetch is outstanding at a time.
// Ports:
//  clk    system clock
//  reset  asynchronous active-high reset
//  bus    fetch_unit_if.master: ROM address/data, decode handshake,
//         redirect inputs, flush, link address and fetch counter
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32'd8,
  parameter int unsigned DATA_W   = 32'd32,
  parameter int unsigned ROM_LAT  = 32'd1,
  parameter int unsigned RESET_PC = 32'd0,
  parameter int unsigned LINK_OFS = 32'd2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int unsigned     LAT_W    = $clog2(ROM_LAT + 32'd1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT);
  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);

  fetch_state_e      state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [31:0]       fetch_count_q, fetch_count_d;
  logic [ADDR_W-1:0] next_pc_s;
  logic              handshake_s;

  assign handshake_s = instr_valid_q & bus.instr_ready;

  fetch_unit_next_pc_calc #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_next_pc (
    .instr_pc_i      (instr_pc_q),
    .redirect_valid_i(bus.redirect_valid),
    .kind_i          (bus.redirect_kind),
    .taken_i         (bus.branch_taken),
    .imm_i           (bus.imm),
    .jr_target_i     (bus.jr_target),
    .next_pc_o       (next_pc_s)
  );

  // Next-state logic. Flush wins over everything, including a handshake in
  // the same cycle; restarting FETCH also drops any data still in the ROM.
  always_comb begin
    state_d       = state_q;
    lat_cnt_d     = lat_cnt_q;
    pc_d          = pc_q;
    instr_pc_d    = instr_pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;
    if (bus.flush_valid) begin
      state_d       = ST_FETCH;
      lat_cnt_d     = {LAT_W{1'b0}};
      pc_d          = bus.flush_pc;
      instr_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (lat_cnt_q == LAT_LAST) begin
            instr_d       = bus.rom_q;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            state_d       = ST_VALID;
          end else begin
            lat_cnt_d = lat_cnt_q + LAT_W'(1);
          end
        end
        ST_VALID: begin
          if (handshake_s) begin
            fetch_count_d = fetch_count_q + 32'd1;
            pc_d          = next_pc_s;
            lat_cnt_d     = {LAT_W{1'b0}};
            instr_valid_d = 1'b0;
            state_d       = ST_FETCH;
          end else begin
            state_d = ST_VALID;
          end
        end
        default: begin
          state_d       = ST_FETCH;
          lat_cnt_d     = {LAT_W{1'b0}};
          instr_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      lat_cnt_q     <= {LAT_W{1'b0}};
      pc_q          <= PC_RST;
      instr_pc_q    <= PC_RST;
      instr_q       <= {DATA_W{1'b0}};
      instr_valid_q <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      lat_cnt_q     <= lat_cnt_d;
      pc_q          <= pc_d;
      instr_pc_q    <= instr_pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // The PC register is the ROM address, so it only moves on entry to FETCH.
  assign bus.rom_addr    = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.link_addr   = instr_pc_q + ADDR_W'(LINK_OFS);
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic clk;
  logic reset_a;
  logic reset_b;
  int   checks;
  int   failures;
  int   exp_count;

  fetch_unit_if #(.ADDR_W(8), .DATA_W(32)) bus_a ();
  fetch_unit_if #(.ADDR_W(8), .DATA_W(32)) bus_b ();

  fetch_unit #(.ADDR_W(8), .DATA_W(32), .ROM_LAT(1), .RESET_PC(0), .LINK_OFS(2))
    dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
  fetch_unit #(.ADDR_W(8), .DATA_W(32), .ROM_LAT(3), .RESET_PC(4), .LINK_OFS(2))
    dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: low addresses hold their own address, others a tagged word
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    if (a < 8'd3) rom_word = {24'd0, a};
    else          rom_word = {a, 8'h5A, 8'hC3, a};
  endfunction

  // Synchronous ROM models: 1-cycle for dut_a, 3-cycle for dut_b
  logic [31:0] pipe_a;
  logic [31:0] pipe_b0, pipe_b1, pipe_b2;
  always @(posedge clk) begin
    pipe_a  <= rom_word(bus_a.rom_addr);
    pipe_b0 <= rom_word(bus_b.rom_addr);
    pipe_b1 <= pipe_b0;
    pipe_b2 <= pipe_b1;
  end
  assign bus_a.rom_q = pipe_a;
  assign bus_b.rom_q = pipe_b2;

  typedef struct {
    logic [7:0]  start_pc;
    logic        rv;
    logic [1:0]  kind;
    logic        taken;
    logic [15:0] imm;
    logic [31:0] jr;
    logic [7:0]  exp_next;
    logic [7:0]  exp_link;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input bit use_b, input int budget);
    int n;
    n = 0;
    while (((use_b ? bus_b.instr_valid : bus_a.instr_valid) !== 1'b1) && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid", {31'd0, (use_b ? bus_b.instr_valid : bus_a.instr_valid)}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; exp_count = 0;
    vecs[0] = '{8'h10, 1'b1, 2'b00, 1'b1, 16'hFFFC, 32'h0,         8'h0D, 8'h12};
    vecs[1] = '{8'h10, 1'b1, 2'b00, 1'b0, 16'hFFFC, 32'h0,         8'h11, 8'h12};
    vecs[2] = '{8'h30, 1'b1, 2'b10, 1'b0, 16'h0000, 32'h1234_5678, 8'h78, 8'h32};
    vecs[3] = '{8'h20, 1'b1, 2'b11, 1'b0, 16'h0040, 32'h0,         8'h40, 8'h22};
    vecs[4] = '{8'h50, 1'b1, 2'b01, 1'b0, 16'hAB33, 32'h0,         8'h33, 8'h52};
    vecs[5] = '{8'hFF, 1'b0, 2'b01, 1'b1, 16'h0040, 32'hDEAD_BEEF, 8'h00, 8'h01};
    vecs[6] = '{8'hF0, 1'b1, 2'b00, 1'b1, 16'h0020, 32'h0,         8'h11, 8'hF2};
    vecs[7] = '{8'h41, 1'b1, 2'b10, 1'b1, 16'h7F00, 32'hFFFF_FF9C, 8'h9C, 8'h43};

    reset_a = 1'b1; reset_b = 1'b1;
    bus_a.instr_ready = 1'b0; bus_a.redirect_valid = 1'b0; bus_a.redirect_kind = 2'b00;
    bus_a.branch_taken = 1'b0; bus_a.imm = 16'h0; bus_a.jr_target = 32'h0;
    bus_a.flush_valid = 1'b0; bus_a.flush_pc = 8'h0;
    bus_b.instr_ready = 1'b0; bus_b.redirect_valid = 1'b0; bus_b.redirect_kind = 2'b00;
    bus_b.branch_taken = 1'b0; bus_b.imm = 16'h0; bus_b.jr_target = 32'h0;
    bus_b.flush_valid = 1'b0; bus_b.flush_pc = 8'h0;

    tick(); tick();
    check("rst_rom_addr", {24'd0, bus_a.rom_addr}, 32'h0);
    check("rst_valid",    {31'd0, bus_a.instr_valid}, 32'h0);
    check("rst_instr",    bus_a.instr, 32'h0);
    check("rst_instr_pc", {24'd0, bus_a.instr_pc}, 32'h0);
    check("rst_count",    bus_a.fetch_count, 32'h0);

    // Sequential stream with ready held high: one instruction every 3 cycles
    reset_a = 1'b0;
    bus_a.instr_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("seq_rom_addr", {24'd0, bus_a.rom_addr}, i / 3);
      check("seq_valid", {31'd0, bus_a.instr_valid}, ((i % 3) == 2) ? 32'd1 : 32'd0);
      if (bus_a.instr_valid === 1'b1) begin
        check("seq_instr", bus_a.instr, i / 3);
        check("seq_instr_pc", {24'd0, bus_a.instr_pc}, i / 3);
      end
      tick();
    end
    exp_count = 3;
    bus_a.instr_ready = 1'b0;
    check("seq_count", bus_a.fetch_count, 32'd3);
    check("seq_rom_addr3", {24'd0, bus_a.rom_addr}, 32'd3);

    // Redirect table: flush to start_pc, wait, accept with the redirect, check target
    for (int i = 0; i < 8; i++) begin
      bus_a.flush_valid = 1'b1; bus_a.flush_pc = vecs[i].start_pc;
      tick();
      bus_a.flush_valid = 1'b0;
      check("vec_flush_addr", {24'd0, bus_a.rom_addr}, {24'd0, vecs[i].start_pc});
      check("vec_flush_valid", {31'd0, bus_a.instr_valid}, 32'd0);
      // redirect inputs outside a handshake must have no effect
      bus_a.redirect_valid = 1'b1; bus_a.redirect_kind = 2'b01; bus_a.imm = 16'h00EE;
      wait_valid(1'b0, 8);
      check("vec_instr_pc", {24'd0, bus_a.instr_pc}, {24'd0, vecs[i].start_pc});
      check("vec_instr", bus_a.instr, rom_word(vecs[i].start_pc));
      check("vec_link", {24'd0, bus_a.link_addr}, {24'd0, vecs[i].exp_link});
      check("vec_count_hold", bus_a.fetch_count, exp_count);
      bus_a.redirect_valid = vecs[i].rv;   bus_a.redirect_kind = vecs[i].kind;
      bus_a.branch_taken   = vecs[i].taken; bus_a.imm = vecs[i].imm;
      bus_a.jr_target      = vecs[i].jr;   bus_a.instr_ready = 1'b1;
      tick();
      bus_a.instr_ready = 1'b0; bus_a.redirect_valid = 1'b0;
      exp_count++;
      check("vec_next_addr", {24'd0, bus_a.rom_addr}, {24'd0, vecs[i].exp_next});
      check("vec_valid_drop", {31'd0, bus_a.instr_valid}, 32'd0);
      check("vec_count", bus_a.fetch_count, exp_count);
    end

    // Ready while not valid is ignored; then a 5-cycle stall in VALID
    bus_a.flush_valid = 1'b1; bus_a.flush_pc = 8'h60;
    tick();
    bus_a.flush_valid = 1'b0; bus_a.instr_ready = 1'b1;
    tick();
    bus_a.instr_ready = 1'b0;
    check("ign_ready_count", bus_a.fetch_count, exp_count);
    check("ign_ready_addr", {24'd0, bus_a.rom_addr}, 32'h60);
    wait_valid(1'b0, 8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_instr", bus_a.instr, rom_word(8'h60));
      check("stall_instr_pc", {24'd0, bus_a.instr_pc}, 32'h60);
      check("stall_rom_addr", {24'd0, bus_a.rom_addr}, 32'h60);
      check("stall_count", bus_a.fetch_count, exp_count);
      check("stall_valid", {31'd0, bus_a.instr_valid}, 32'd1);
    end
    bus_a.instr_ready = 1'b1;
    tick();
    bus_a.instr_ready = 1'b0;
    exp_count++;
    check("stall_release_addr", {24'd0, bus_a.rom_addr}, 32'h61);
    check("stall_release_count", bus_a.fetch_count, exp_count);

    // Flush in the same cycle as a handshake carrying a jump
    bus_a.flush_valid = 1'b1; bus_a.flush_pc = 8'h20;
    tick();
    bus_a.flush_valid = 1'b0;
    wait_valid(1'b0, 8);
    bus_a.instr_ready = 1'b1; bus_a.redirect_valid = 1'b1;
    bus_a.redirect_kind = 2'b01; bus_a.imm = 16'h0040;
    bus_a.flush_valid = 1'b1; bus_a.flush_pc = 8'h80;
    tick();
    check("flush_hs_valid", {31'd0, bus_a.instr_valid}, 32'd0);
    check("flush_hs_addr", {24'd0, bus_a.rom_addr}, 32'h80);
    check("flush_hs_count", bus_a.fetch_count, exp_count);
    bus_a.flush_pc = 8'h90;
    tick();
    check("flush_hold_addr0", {24'd0, bus_a.rom_addr}, 32'h90);
    bus_a.flush_pc = 8'h92;
    tick();
    check("flush_hold_addr1", {24'd0, bus_a.rom_addr}, 32'h92);
    check("flush_hold_valid", {31'd0, bus_a.instr_valid}, 32'd0);
    bus_a.flush_valid = 1'b0; bus_a.instr_ready = 1'b0; bus_a.redirect_valid = 1'b0;
    tick();
    check("flush_lat_c1", {31'd0, bus_a.instr_valid}, 32'd0);
    tick();
    check("flush_lat_c2", {31'd0, bus_a.instr_valid}, 32'd1);
    check("flush_lat_pc", {24'd0, bus_a.instr_pc}, 32'h92);
    check("flush_lat_instr", bus_a.instr, rom_word(8'h92));
    check("flush_lat_count", bus_a.fetch_count, exp_count);

    // Reset mid-VALID on dut_a takes effect immediately
    #2 reset_a = 1'b1;
    #1;
    check("rstv_valid", {31'd0, bus_a.instr_valid}, 32'd0);
    check("rstv_instr", bus_a.instr, 32'h0);
    check("rstv_instr_pc", {24'd0, bus_a.instr_pc}, 32'h0);
    check("rstv_count", bus_a.fetch_count, 32'h0);
    check("rstv_rom_addr", {24'd0, bus_a.rom_addr}, 32'h0);

    // ROM_LAT=3 instance: valid 4 cycles after FETCH entry
    tick();
    reset_b = 1'b0;
    bus_b.instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("lat3_valid", {31'd0, bus_b.instr_valid}, (i == 4) ? 32'd1 : 32'd0);
      check("lat3_rom_addr", {24'd0, bus_b.rom_addr}, 32'h4);
      tick();
    end
    bus_b.instr_ready = 1'b0;
    check("lat3_instr", bus_b.instr, rom_word(8'h04));
    check("lat3_next_addr", {24'd0, bus_b.rom_addr}, 32'h5);
    check("lat3_count", bus_b.fetch_count, 32'd1);

    // Sequential wrap from 0xFF
    bus_b.flush_valid = 1'b1; bus_b.flush_pc = 8'hFF;
    tick();
    bus_b.flush_valid = 1'b0;
    wait_valid(1'b1, 10);
    check("wrap_instr_pc", {24'd0, bus_b.instr_pc}, 32'hFF);
    check("wrap_link", {24'd0, bus_b.link_addr}, 32'h01);
    bus_b.instr_ready = 1'b1;
    tick();
    bus_b.instr_ready = 1'b0;
    check("wrap_rom_addr", {24'd0, bus_b.rom_addr}, 32'h00);
    check("wrap_count", bus_b.fetch_count, 32'd2);

    // Reset mid-FETCH
    tick(); tick();
    #2 reset_b = 1'b1;
    #1;
    check("rstf_rom_addr", {24'd0, bus_b.rom_addr}, 32'h4);
    check("rstf_valid", {31'd0, bus_b.instr_valid}, 32'd0);
    check("rstf_instr", bus_b.instr, 32'h0);
    check("rstf_instr_pc", {24'd0, bus_b.instr_pc}, 32'h4);
    check("rstf_count", bus_b.fetch_count, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
